line_scroll_buffer: RTL and testbench
=====================================

// Module: line_scroll_buffer
// PURPOSE
//  Circular frame store for the generated playfield. Captures each WIDTH-bit line from
//  the line generator, commits it as the new top row at the next frame start (no tearing),
//  and scrolls older rows down one position. The VGA pixel path reads one bit per pixel.
// PARAMETERS
//  WIDTH     640  bits per line; pixels per row
//  ROWS      480  stored rows (any value >= 2, need not be a power of 2)
//  FILL_VAL  1'b1 pixel value for rows never written since reset, and for out-of-range reads
//  XW        10   width of rd_x_i, >= clog2(WIDTH)
//  YW        9    width of rd_y_i and head_o, >= clog2(ROWS)
// PORTS
//  clk_i          in   1      system clock
//  reset_i        in   1      asynchronous, active-low reset
//  line_i         in   WIDTH  line from the generator; sampled when scroll_i=1
//  scroll_i       in   1      one-cycle strobe: a new line is available on line_i
//  frame_start_i  in   1      one-cycle strobe at vblank start; commits the pending line
//  rd_en_i        in   1      pixel read request
//  rd_x_i         in   XW     pixel column; 0 is column 0
//  rd_y_i         in   YW     screen row; 0 is the newest (top) row
//  pix_o          out  1      pixel value, 2 cycles after rd_en_i
//  pix_valid_o    out  1      qualifies pix_o
//  head_o         out  YW     physical index of the top row
//  filled_o       out  1      1 once all ROWS rows have been written since reset
//  overrun_o      out  1      sticky: a pending line was overwritten before commit
// BEHAVIOUR
//  Reset (async, reset_i=0): head=0, pending=0, row_valid=0 (all rows), overrun_o=0,
//   pix_o=0, pix_valid_o=0, read pipeline cleared. Memory contents are not reset;
//   row_valid masks them. Reset mid-frame discards the pending line.
//  Capture: scroll_i=1 -> staging<=line_i, pending<=1. If pending was already 1 and no
//   commit happens that cycle, the old staging is lost and overrun_o<=1 (cleared only by reset).
//  Commit on frame_start_i=1:
//   - pending=1: write staging to row nh = (head==0 ? ROWS-1 : head-1); set row_valid[nh]; head<=nh.
//     If scroll_i=1 in the same cycle, line_i becomes the new staging and pending stays 1 (no overrun).
//   - pending=0 and scroll_i=1: write line_i directly to nh; head<=nh; pending stays 0.
//   - pending=0 and scroll_i=0: no change.
//   At most one commit per frame_start_i, i.e. at most one row of scroll per frame.
//  Read pipeline (one request per cycle accepted, no back-pressure):
//   - Stage 1 (cycle of rd_en_i): phys = head+rd_y_i, minus ROWS if >= ROWS, uses the pre-commit
//     head. Register row data and row_valid[phys], and an out-of-range flag
//     (rd_x_i>=WIDTH or rd_y_i>=ROWS); x is registered as x_q.
//   - Stage 2: pix_o <= (oor | !valid) ? FILL_VAL : row_q[x_q]; pix_valid_o <= stage-1 enable.
//   - Latency is exactly 2 cycles; pix_valid_o is 0 in any cycle not 2 after a rd_en_i.
//   - Read and commit of the same physical row in the same cycle returns the old data.
//  filled_o = &row_valid; head_o = head register.
//  Wrap-around: head decrements 0 -> ROWS-1; phys addition wraps modulo ROWS with no modulo
//   operator (compare and subtract).
// STRUCTURE
//  Shared package/header: WIDTH, ROWS, XW, YW, FILL_VAL, shared with line generator and VGA timing.
//  Sub-module lsb_row_ram: 1 write / 1 read, registered read, WIDTH x ROWS, no reset, infers BRAM.
//  Top level holds staging, pending/overrun, head, the row_valid vector and the read pipeline.
// TESTING
//  1 Reset, then read (x=5,y=0) -> pix_o=1 (FILL_VAL), pix_valid_o=1 two cycles later; filled_o=0.
//  2 scroll_i with line_i=640'h0...01, frame_start_i -> head_o=479; read (0,0)=0... bit0=1,
//    read (1,0)=0; read (0,1)=FILL_VAL.
//  3 Two scroll_i without frame_start (A then B) -> overrun_o=1; commit writes B; A never appears.
//  4 scroll_i and frame_start_i same cycle, pending=0 -> direct commit, pending stays 0;
//    with pending=1 -> old staging committed, new line pending, overrun_o stays 0.
//  5 480 scroll+commit pairs -> head wraps 0->479->...->0, filled_o=1 after the 480th commit;
//    read y=479 returns the first line written.
//  6 Reads with x=640 or y=480 -> FILL_VAL; assert reset_i=0 mid-pipeline -> pix_valid_o=0
//    immediately, pending cleared, and the next read returns FILL_VAL.

Source files
------------

// File: rtl/line_scroll_buffer_pkg.sv
// Shared playfield geometry for the line generator, the scroll buffer and the VGA timing.
package line_scroll_buffer_pkg;

  localparam int unsigned WIDTH    = 640;
  localparam int unsigned ROWS     = 480;
  localparam int unsigned XW       = 10;
  localparam int unsigned YW       = 9;
  localparam logic        FILL_VAL = 1'b1;

endpackage

// File: rtl/line_scroll_buffer_if.sv
// Line capture, commit strobe and pixel read bundle of the scroll buffer.
interface line_scroll_buffer_if;
  import line_scroll_buffer_pkg::*;

  logic [WIDTH-1:0] line_i;
  logic             scroll_i;
  logic             frame_start_i;
  logic             rd_en_i;
  logic [XW-1:0]    rd_x_i;
  logic [YW-1:0]    rd_y_i;
  logic             pix_o;
  logic             pix_valid_o;
  logic [YW-1:0]    head_o;
  logic             filled_o;
  logic             overrun_o;

  modport master (
    output line_i, scroll_i, frame_start_i, rd_en_i, rd_x_i, rd_y_i,
    input  pix_o, pix_valid_o, head_o, filled_o, overrun_o
  );

  modport slave (
    input  line_i, scroll_i, frame_start_i, rd_en_i, rd_x_i, rd_y_i,
    output pix_o, pix_valid_o, head_o, filled_o, overrun_o
  );

endinterface

// File: rtl/lsb_row_ram.sv
// Row store: one write port, one registered read port, no reset so it maps onto block RAM.
module lsb_row_ram #(
  parameter int unsigned Width = 640,
  parameter int unsigned Rows  = 480,
  parameter int unsigned AddrW = 9
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Rows];

  // Read-before-write: a same-cycle read of the written row sees the old contents.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/line_scroll_buffer.sv
// Circular frame store: stages a generated line, commits it as the new top row at frame
// start, and serves single-pixel reads with a fixed two-cycle latency.
module line_scroll_buffer
  import line_scroll_buffer_pkg::*;
(
  input logic                 clk_i,
  input logic                 reset_i,
  line_scroll_buffer_if.slave bus
);

  logic [WIDTH-1:0] staging_q, wdata;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic [YW-1:0]    head_q, head_d, new_head;
  logic [ROWS-1:0]  row_valid_q, row_valid_d;
  logic             commit;

  always_comb begin
    new_head    = (head_q == '0) ? YW'(ROWS - 1) : head_q - 1'b1;
    commit      = bus.frame_start_i & (pending_q | bus.scroll_i);
    wdata       = pending_q ? staging_q : bus.line_i;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    head_d      = head_q;
    row_valid_d = row_valid_q;
    if (bus.frame_start_i) begin
      pending_d = pending_q & bus.scroll_i;
    end else if (bus.scroll_i) begin
      pending_d = 1'b1;
      if (pending_q) overrun_d = 1'b1;
    end
    if (commit) begin
      head_d                = new_head;
      row_valid_d[new_head] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      head_q      <= '0;
      row_valid_q <= '0;
    end else begin
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      head_q      <= head_d;
      row_valid_q <= row_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (bus.scroll_i) staging_q <= bus.line_i;
  end

  // Stage 1: logical row to physical row, wrapping by compare-and-subtract.
  logic [YW:0]      sum, sum_wrap;
  logic [YW-1:0]    phys;
  logic             oor_x, oor_y, oor;
  logic [WIDTH-1:0] row_q;

  always_comb begin
    sum      = {1'b0, head_q} + {1'b0, bus.rd_y_i};
    sum_wrap = (sum >= (YW + 1)'(ROWS)) ? sum - (YW + 1)'(ROWS) : sum;
    oor_x    = {1'b0, bus.rd_x_i} >= (XW + 1)'(WIDTH);
    oor_y    = {1'b0, bus.rd_y_i} >= (YW + 1)'(ROWS);
    oor      = oor_x | oor_y;
    phys     = oor_y ? '0 : sum_wrap[YW-1:0];
  end

  lsb_row_ram #(
    .Width (WIDTH),
    .Rows  (ROWS),
    .AddrW (YW)
  ) u_row_ram (
    .clk_i   (clk_i),
    .we_i    (commit),
    .waddr_i (new_head),
    .wdata_i (wdata),
    .re_i    (bus.rd_en_i),
    .raddr_i (phys),
    .rdata_o (row_q)
  );

  logic          rd_en_q, valid_q, oor_q, pix_q, pix_valid_q;
  logic [XW-1:0] x_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_en_q     <= 1'b0;
      valid_q     <= 1'b0;
      oor_q       <= 1'b0;
      x_q         <= '0;
      pix_q       <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      rd_en_q     <= bus.rd_en_i;
      if (bus.rd_en_i) begin
        valid_q <= row_valid_q[phys];
        oor_q   <= oor;
        x_q     <= oor_x ? '0 : bus.rd_x_i;
      end
      pix_valid_q <= rd_en_q;
      if (rd_en_q) pix_q <= (oor_q | !valid_q) ? FILL_VAL : row_q[x_q];
    end
  end

  assign bus.pix_o       = pix_q;
  assign bus.pix_valid_o = pix_valid_q;
  assign bus.head_o      = head_q;
  assign bus.filled_o    = &row_valid_q;
  assign bus.overrun_o   = overrun_q;

endmodule

// File: tb/tb_line_scroll_buffer.sv
// Directed bench for line_scroll_buffer: commit/overrun sequences plus a table of pixel reads.
module tb_line_scroll_buffer;
  import line_scroll_buffer_pkg::*;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  line_scroll_buffer_if bus ();

  line_scroll_buffer dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          exp;
  } rvec_t;

  rvec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] pat(input int k);
    logic [WIDTH-1:0] l;
    l          = '0;
    l[15:0]    = k[15:0];
    l[WIDTH-1] = 1'b1;
    return l;
  endfunction

  // All tasks are entered and left on a falling edge.
  task automatic step(input logic sc, input logic fs, input logic [WIDTH-1:0] l);
    bus.scroll_i      = sc;
    bus.frame_start_i = fs;
    bus.line_i        = l;
    @(negedge clk);
    bus.scroll_i      = 1'b0;
    bus.frame_start_i = 1'b0;
  endtask

  task automatic rd(input string name, input int x, input int y, input logic exp);
    bus.rd_en_i = 1'b1;
    bus.rd_x_i  = XW'(x);
    bus.rd_y_i  = YW'(y);
    @(negedge clk);
    bus.rd_en_i = 1'b0;
    check({name, "_valid_early"}, 32'(bus.pix_valid_o), 32'd0);
    @(negedge clk);
    check({name, "_valid"}, 32'(bus.pix_valid_o), 32'd1);
    check({name, "_pix"}, 32'(bus.pix_o), 32'(exp));
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_head", 32'(bus.head_o), 32'd0);
    check("rst_overrun", 32'(bus.overrun_o), 32'd0);
    check("rst_filled", 32'(bus.filled_o), 32'd0);
    check("rst_pix_valid", 32'(bus.pix_valid_o), 32'd0);
    check("rst_pix", 32'(bus.pix_o), 32'd0);
    reset_i = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int eh;
    bus.line_i        = '0;
    bus.scroll_i      = 1'b0;
    bus.frame_start_i = 1'b0;
    bus.rd_en_i       = 1'b0;
    bus.rd_x_i        = '0;
    bus.rd_y_i        = '0;

    // 1: reset, unwritten row reads FILL_VAL
    do_reset();
    rd("t1_unwritten", 5, 0, 1'b1);
    check("t1_filled", 32'(bus.filled_o), 32'd0);

    // 2: single line via staging, then commit
    step(1'b1, 1'b0, WIDTH'(1));
    check("t2_head_before", 32'(bus.head_o), 32'd0);
    step(1'b0, 1'b1, '0);
    check("t2_head", 32'(bus.head_o), 32'd479);
    rd("t2_x0y0", 0, 0, 1'b1);
    rd("t2_x1y0", 1, 0, 1'b0);
    rd("t2_x0y1", 0, 1, 1'b1);
    check("t2_overrun", 32'(bus.overrun_o), 32'd0);

    // 3: A then B without commit: overrun, B committed, A lost
    step(1'b1, 1'b0, WIDTH'(4));
    step(1'b1, 1'b0, WIDTH'(8));
    check("t3_overrun", 32'(bus.overrun_o), 32'd1);
    step(1'b0, 1'b1, '0);
    check("t3_head", 32'(bus.head_o), 32'd478);
    rd("t3_b_bit", 3, 0, 1'b1);
    rd("t3_a_bit", 2, 0, 1'b0);
    rd("t3_old_row", 0, 1, 1'b1);
    step(1'b0, 1'b1, '0);
    check("t3_no_stale_pending", 32'(bus.head_o), 32'd478);
    check("t3_overrun_sticky", 32'(bus.overrun_o), 32'd1);

    // 4: same-cycle scroll+commit, without and with a pending line
    do_reset();
    step(1'b1, 1'b1, WIDTH'(16));
    check("t4a_head", 32'(bus.head_o), 32'd479);
    rd("t4a_c_bit", 4, 0, 1'b1);
    rd("t4a_c_bit0", 0, 0, 1'b0);
    step(1'b0, 1'b1, '0);
    check("t4a_not_pending", 32'(bus.head_o), 32'd479);
    step(1'b1, 1'b0, WIDTH'(32));
    step(1'b1, 1'b1, WIDTH'(64));
    check("t4b_head", 32'(bus.head_o), 32'd478);
    check("t4b_overrun", 32'(bus.overrun_o), 32'd0);
    rd("t4b_d_bit", 5, 0, 1'b1);
    rd("t4b_e_absent", 6, 0, 1'b0);
    step(1'b0, 1'b1, '0);
    check("t4b_head2", 32'(bus.head_o), 32'd477);
    rd("t4b_e_bit", 6, 0, 1'b1);
    rd("t4b_c_row", 4, 2, 1'b1);
    check("t4b_overrun2", 32'(bus.overrun_o), 32'd0);

    // 6a: out-of-range and unwritten rows
    rd("t6_x640", 640, 0, 1'b1);
    rd("t6_y480", 6, 480, 1'b1);
    rd("t6_y479_unwritten", 0, 479, 1'b1);
    rd("t6_y3_unwritten", 0, 3, 1'b1);

    // 5: fill all rows, head wraps, filled_o rises on the last commit
    do_reset();
    eh = 0;
    for (int k = 0; k < int'(ROWS); k++) begin
      step(1'b1, 1'b1, pat(k));
      eh = (eh == 0) ? int'(ROWS) - 1 : eh - 1;
      check($sformatf("t5_head_%0d", k), 32'(bus.head_o), 32'(eh));
      check($sformatf("t5_filled_%0d", k), 32'(bus.filled_o), 32'(k == int'(ROWS) - 1));
    end
    vecs[0]  = '{x: 10'd0,    y: 9'd0,   exp: 1'b1};
    vecs[1]  = '{x: 10'd5,    y: 9'd0,   exp: 1'b0};
    vecs[2]  = '{x: 10'd8,    y: 9'd0,   exp: 1'b1};
    vecs[3]  = '{x: 10'd9,    y: 9'd0,   exp: 1'b0};
    vecs[4]  = '{x: 10'd0,    y: 9'd1,   exp: 1'b0};
    vecs[5]  = '{x: 10'd1,    y: 9'd1,   exp: 1'b1};
    vecs[6]  = '{x: 10'd2,    y: 9'd100, exp: 1'b0};
    vecs[7]  = '{x: 10'd0,    y: 9'd100, exp: 1'b1};
    vecs[8]  = '{x: 10'd0,    y: 9'd479, exp: 1'b0};
    vecs[9]  = '{x: 10'd639,  y: 9'd479, exp: 1'b1};
    vecs[10] = '{x: 10'd640,  y: 9'd0,   exp: 1'b1};
    vecs[11] = '{x: 10'd1023, y: 9'd511, exp: 1'b1};
    for (int i = 0; i < 12; i++) begin
      rd($sformatf("t5_vec%0d", i), int'(vecs[i].x), int'(vecs[i].y), vecs[i].exp);
    end
    step(1'b1, 1'b1, pat(480));
    check("t5_rewrap_head", 32'(bus.head_o), 32'd479);
    check("t5_still_filled", 32'(bus.filled_o), 32'd1);
    rd("t5_rw_y0_b5", 5, 0, 1'b1);
    rd("t5_rw_y0_b0", 0, 0, 1'b0);
    rd("t5_rw_y479_b0", 0, 479, 1'b1);
    rd("t5_rw_y479_b1", 1, 479, 1'b0);
    rd("t5_rw_y1_b5", 5, 1, 1'b0);

    // 6b: reset with a pending line and two reads in flight
    step(1'b1, 1'b0, pat(7));
    bus.rd_en_i = 1'b1;
    bus.rd_x_i  = '0;
    bus.rd_y_i  = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.rd_en_i = 1'b0;
    check("t6_pre_valid", 32'(bus.pix_valid_o), 32'd1);
    check("t6_pre_pix", 32'(bus.pix_o), 32'd0);
    reset_i = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.pix_valid_o), 32'd0);
    check("t6_rst_pix", 32'(bus.pix_o), 32'd0);
    check("t6_rst_head", 32'(bus.head_o), 32'd0);
    check("t6_rst_filled", 32'(bus.filled_o), 32'd0);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    check("t6_after_valid", 32'(bus.pix_valid_o), 32'd0);
    step(1'b0, 1'b1, '0);
    check("t6_pending_cleared", 32'(bus.head_o), 32'd0);
    check("t6_after_valid2", 32'(bus.pix_valid_o), 32'd0);
    rd("t6_fill_after_rst", 0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
